// File: rtl/lcd_feed_pkg.sv
// Shared types and constants for the multi-line LCD feed controller.
package lcd_feed_pkg;

   typedef enum logic [3:0] {
      ST_PAUSE       = 4'd0,
      ST_CLEAR_RUN   = 4'd1,
      ST_CLEAR_DLY   = 4'd2,
      ST_CLEAR_WAIT  = 4'd3,
      ST_LINE_RUN    = 4'd4,
      ST_LINE_DLY    = 4'd5,
      ST_LINE_WAIT   = 4'd6,
      ST_REFRESH_DLY = 4'd7
   } t_lcd_feed_state;

   // Default delays at the 2.5 MHz tick rate.
   localparam int c_one_ms_ticks       = 2500;
   localparam int c_fifth_second_ticks = 500000;

   // Line index width; a single-line display still gets a 1-bit index.
   function automatic int lcd_line_idx_width(input int line_count);
      return (line_count <= 2) ? 1 : $clog2(line_count);
   endfunction

endpackage

// File: rtl/lcd_feed_step_timer.sv
// Tick-gated saturating up-counter with synchronous clear, used for the
// per-step delay timer and for the optional watchdog.
module lcd_feed_step_timer
   import lcd_feed_pkg::*;
#(
   parameter int parm_width = 24
)(
   input  logic                  i_clk_20mhz,
   input  logic                  i_rst_20mhz,
   input  logic                  i_ce_2_5mhz,
   input  logic                  i_clear,
   output logic [parm_width-1:0] o_count
);

   // Count ticks, hold at all-ones, restart from zero on clear.
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         o_count <= '0;
      end else if (i_ce_2_5mhz) begin
         if (i_clear) begin
            o_count <= '0;
         end else if (o_count != {parm_width{1'b1}}) begin
            o_count <= o_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_multi_line_feed.sv
// Timed Moore FSM feeding clear / line-write commands to the LCD driver.
// Optional watchdog: define LCD_FEED_TIMEOUT_EN.
//
// state          | meaning
// ST_PAUSE       | waiting for driver ready and a refresh trigger
// ST_CLEAR_RUN   | clear strobe high until driver drops ready
// ST_CLEAR_DLY   | hold parm_cmd_delay_ticks after the clear
// ST_CLEAR_WAIT  | waiting for driver ready before line 0
// ST_LINE_RUN    | line strobe high until driver drops ready
// ST_LINE_DLY    | hold parm_cmd_delay_ticks after a line write
// ST_LINE_WAIT   | waiting for driver ready before the next line
// ST_REFRESH_DLY | hold parm_refresh_ticks before the next cycle
module lcd_multi_line_feed
   import lcd_feed_pkg::*;
#(
   parameter int parm_line_count      = 2,
   parameter int parm_cmd_delay_ticks = c_one_ms_ticks,
   parameter int parm_refresh_ticks   = 495000,
   parameter int parm_timer_bits      = 24,
   parameter int parm_timeout_ticks   = 25000
)(
   input  logic                                               i_clk_20mhz,
   input  logic                                               i_rst_20mhz,
   input  logic                                               i_ce_2_5mhz,
   input  logic                                               i_lcd_command_ready,
   input  logic                                               i_on_demand_mode,
   input  logic                                               i_refresh_request,
   output logic                                               o_lcd_wr_clear_display,
   output logic [parm_line_count-1:0]                         o_lcd_wr_text_line,
   output logic [lcd_line_idx_width(parm_line_count)-1:0]     o_lcd_line_index,
   output logic                                               o_lcd_feed_is_idle,
   output logic                                               o_lcd_feed_timeout
);

   localparam int c_idx_w = lcd_line_idx_width(parm_line_count);
   localparam logic [parm_timer_bits-1:0] c_cmd_last     = parm_timer_bits'(parm_cmd_delay_ticks - 1);
   localparam logic [parm_timer_bits-1:0] c_refresh_last = parm_timer_bits'(parm_refresh_ticks - 1);
   localparam logic [c_idx_w-1:0]         c_idx_last     = c_idx_w'(parm_line_count - 1);

   if (parm_line_count < 1 || parm_line_count > 8 ||
       parm_cmd_delay_ticks < 1 || parm_refresh_ticks < 1 || parm_timeout_ticks < 1 ||
       longint'(parm_cmd_delay_ticks) > (longint'(1) << parm_timer_bits) ||
       longint'(parm_refresh_ticks) > (longint'(1) << parm_timer_bits)) begin : g_bad_params
      $error("lcd_multi_line_feed: parameter out of range");
   end

   t_lcd_feed_state            state_q;
   t_lcd_feed_state            state_d;
   logic                       state_change;
   logic                       enter_clear;
   logic [parm_timer_bits-1:0] step_count;
   logic [c_idx_w-1:0]         line_idx_q;
   logic                       pending_q;
   logic                       wd_expired;

   assign state_change = (state_d != state_q);
   assign enter_clear  = (state_d == ST_CLEAR_RUN) && (state_q != ST_CLEAR_RUN);

   lcd_feed_step_timer #(.parm_width(parm_timer_bits)) u_step_timer (
      .i_clk_20mhz (i_clk_20mhz),
      .i_rst_20mhz (i_rst_20mhz),
      .i_ce_2_5mhz (i_ce_2_5mhz),
      .i_clear     (state_change),
      .o_count     (step_count)
   );

`ifdef LCD_FEED_TIMEOUT_EN
   localparam int c_wd_bits = $clog2(parm_timeout_ticks + 1);
   localparam logic [c_wd_bits-1:0] c_wd_last = c_wd_bits'(parm_timeout_ticks - 1);

   logic                 wd_active;
   logic [c_wd_bits-1:0] wd_count;
   logic                 timeout_q;

   // Watchdog only runs while the FSM is waiting on the driver.
   always_comb begin
      wd_active = (state_q == ST_CLEAR_RUN) || (state_q == ST_CLEAR_WAIT) ||
                  (state_q == ST_LINE_RUN)  || (state_q == ST_LINE_WAIT);
   end

   assign wd_expired = wd_active && (wd_count == c_wd_last);

   lcd_feed_step_timer #(.parm_width(c_wd_bits)) u_watchdog (
      .i_clk_20mhz (i_clk_20mhz),
      .i_rst_20mhz (i_rst_20mhz),
      .i_ce_2_5mhz (i_ce_2_5mhz),
      .i_clear     (state_change || !wd_active),
      .o_count     (wd_count)
   );

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         timeout_q <= 1'b0;
      end else if (i_ce_2_5mhz && wd_expired) begin
         timeout_q <= 1'b1;
      end
   end

   assign o_lcd_feed_timeout = timeout_q;
`else
   assign wd_expired         = 1'b0;
   assign o_lcd_feed_timeout = 1'b0;
`endif

   // Next-state decode; a watchdog expiry overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PAUSE:
            if (i_lcd_command_ready && (!i_on_demand_mode || pending_q)) state_d = ST_CLEAR_RUN;
         ST_CLEAR_RUN:
            if (!i_lcd_command_ready) state_d = ST_CLEAR_DLY;
         ST_CLEAR_DLY:
            if (step_count == c_cmd_last) state_d = ST_CLEAR_WAIT;
         ST_CLEAR_WAIT:
            if (i_lcd_command_ready) state_d = ST_LINE_RUN;
         ST_LINE_RUN:
            if (!i_lcd_command_ready) state_d = ST_LINE_DLY;
         ST_LINE_DLY:
            if (step_count == c_cmd_last) begin
               state_d = (line_idx_q == c_idx_last) ? ST_REFRESH_DLY : ST_LINE_WAIT;
            end
         ST_LINE_WAIT:
            if (i_lcd_command_ready) state_d = ST_LINE_RUN;
         ST_REFRESH_DLY:
            if (step_count == c_refresh_last) state_d = ST_PAUSE;
         default:
            state_d = ST_PAUSE;
      endcase
      if (wd_expired) state_d = ST_PAUSE;
   end

   // State register and line index advance on the 2.5 MHz tick.
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         state_q    <= ST_PAUSE;
         line_idx_q <= '0;
      end else if (i_ce_2_5mhz) begin
         state_q <= state_d;
         if (state_q == ST_CLEAR_WAIT && state_d == ST_LINE_RUN) begin
            line_idx_q <= '0;
         end else if (state_q == ST_LINE_WAIT && state_d == ST_LINE_RUN) begin
            line_idx_q <= line_idx_q + 1'b1;
         end
      end
   end

   // Request pulses are caught on every clock; a new request beats the
   // clear so one arriving mid-refresh queues exactly one more refresh.
   always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
      if (i_rst_20mhz) begin
         pending_q <= 1'b0;
      end else if (i_refresh_request) begin
         pending_q <= 1'b1;
      end else if (i_ce_2_5mhz && (enter_clear || wd_expired)) begin
         pending_q <= 1'b0;
      end
   end

   // Moore output decode.
   always_comb begin
      o_lcd_wr_clear_display = (state_q == ST_CLEAR_RUN);
      o_lcd_wr_text_line     = '0;
      if (state_q == ST_LINE_RUN) begin
         o_lcd_wr_text_line = parm_line_count'(1) << line_idx_q;
      end
      o_lcd_line_index   = line_idx_q;
      o_lcd_feed_is_idle = (state_q == ST_REFRESH_DLY) ||
                           (state_q == ST_PAUSE && i_on_demand_mode && !pending_q);
   end

endmodule

// File: tb/tb_lcd_multi_line_feed.sv
// Directed bench for lcd_multi_line_feed: a 2-line and a 4-line instance
// with short delays, each with a simple ready-handshake driver model.
module tb_lcd_multi_line_feed;
   import lcd_feed_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;
   int   ce_cnt = 0;

   logic       ready_a = 1'b1, mode_a = 1'b0, req_a = 1'b0;
   logic       clr_a, idle_a, to_a;
   logic [1:0] line_a;
   logic [0:0] idx_a;

   logic       ready_b = 1'b1, mode_b = 1'b0, req_b = 1'b0;
   logic       clr_b, idle_b, to_b;
   logic [3:0] line_b;
   logic [1:0] idx_b;

   int checks = 0;
   int errors = 0;

   int  ph_a = 0, ph_b = 0;
   bit  drv_en_a = 1'b1;
   logic       prev_clr_a = 1'b0, prev_clr_b = 1'b0;
   logic [1:0] prev_line_a = '0;
   logic [3:0] prev_line_b = '0;
   int         ev_a[$];
   int         ev_b[$];
   logic [3:0] evl_b[$];
   logic [1:0] evi_b[$];

   lcd_multi_line_feed #(
      .parm_line_count(2), .parm_cmd_delay_ticks(4), .parm_refresh_ticks(20),
      .parm_timer_bits(8), .parm_timeout_ticks(50)
   ) dut_a (
      .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_ce_2_5mhz(ce),
      .i_lcd_command_ready(ready_a), .i_on_demand_mode(mode_a), .i_refresh_request(req_a),
      .o_lcd_wr_clear_display(clr_a), .o_lcd_wr_text_line(line_a), .o_lcd_line_index(idx_a),
      .o_lcd_feed_is_idle(idle_a), .o_lcd_feed_timeout(to_a)
   );

   lcd_multi_line_feed #(
      .parm_line_count(4), .parm_cmd_delay_ticks(4), .parm_refresh_ticks(20),
      .parm_timer_bits(8), .parm_timeout_ticks(50)
   ) dut_b (
      .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_ce_2_5mhz(ce),
      .i_lcd_command_ready(ready_b), .i_on_demand_mode(mode_b), .i_refresh_request(req_b),
      .o_lcd_wr_clear_display(clr_b), .o_lcd_wr_text_line(line_b), .o_lcd_line_index(idx_b),
      .o_lcd_feed_is_idle(idle_b), .o_lcd_feed_timeout(to_b)
   );

   always #25 clk = ~clk;

   // Clock enable: one clock in eight, set up on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         ce = (ce_cnt == 7);
         ce_cnt = (ce_cnt + 1) % 8;
      end
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // Driver model: drop ready 2 ticks after seeing a strobe, restore 10 later.
   task automatic drv(inout int ph, inout logic rdy, input logic strobe);
      if (ph == 0) begin
         if (rdy && strobe) ph = 1;
      end else begin
         ph++;
         if (ph == 3) rdy = 1'b0;
         else if (ph == 13) begin
            rdy = 1'b1;
            ph  = 0;
         end
      end
   endtask

   task automatic ce_tick();
      do @(posedge clk); while (ce !== 1'b1);
      #1;
      if (clr_a && !prev_clr_a) ev_a.push_back(0);
      for (int i = 0; i < 2; i++) if (line_a[i] && !prev_line_a[i]) ev_a.push_back(i + 1);
      if (clr_b && !prev_clr_b) begin
         ev_b.push_back(0); evl_b.push_back(line_b); evi_b.push_back(idx_b);
      end
      for (int i = 0; i < 4; i++) begin
         if (line_b[i] && !prev_line_b[i]) begin
            ev_b.push_back(i + 1); evl_b.push_back(line_b); evi_b.push_back(idx_b);
         end
      end
      prev_clr_a = clr_a; prev_line_a = line_a;
      prev_clr_b = clr_b; prev_line_b = line_b;
      if (drv_en_a) drv(ph_a, ready_a, clr_a | (|line_a));
      drv(ph_b, ready_b, clr_b | (|line_b));
   endtask

   task automatic clear_logs();
      ev_a.delete(); ev_b.delete(); evl_b.delete(); evi_b.delete();
   endtask

   task automatic do_reset(input logic mode);
      rst = 1'b1;
      mode_a = mode; req_a = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1; ph_a = 0; ph_b = 0;
      repeat (3) @(negedge clk);
      prev_clr_a = 1'b0; prev_line_a = '0; prev_clr_b = 1'b0; prev_line_b = '0;
      clear_logs();
      rst = 1'b0;
   endtask

   task automatic pulse_req_a();
      @(negedge clk); req_a = 1'b1;
      @(negedge clk); req_a = 1'b0;
   endtask

   task automatic wait_state_a(input t_lcd_feed_state s, input string name);
      int n;
      n = 0;
      while (dut_a.state_q != s && n < 300) begin
         ce_tick();
         n++;
      end
      checks++;
      if (dut_a.state_q != s) begin
         errors++;
         $display("FAIL %s: state %0d not reached, got %0d", name, s, dut_a.state_q);
      end
   endtask

   function automatic int count_code(input int q[$], input int code);
      int n;
      n = 0;
      foreach (q[i]) if (q[i] == code) n++;
      return n;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (clr_a !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", clr_a); end
      checks++; if (line_a !== 2'b00) begin errors++; $display("FAIL reset_lines: got %b expected 00", line_a); end
      checks++; if (idx_a !== 1'b0) begin errors++; $display("FAIL reset_index: got %0d expected 0", idx_a); end
      checks++; if (idle_a !== 1'b0) begin errors++; $display("FAIL reset_idle_cont: got %b expected 0", idle_a); end
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", to_a); end
      checks++; if (line_b !== 4'b0000) begin errors++; $display("FAIL reset_lines_b: got %b expected 0000", line_b); end
      mode_a = 1'b1; #1;
      checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL reset_idle_ondemand: got %b expected 1", idle_a); end
      mode_a = 1'b0; #1;
   endtask

   task automatic test_continuous();
      t_lcd_feed_state prev_st, st;
      int run_len, n_runs, exp_len;
      do_reset(1'b0);
      prev_st = ST_PAUSE; run_len = 0; n_runs = 0;
      for (int s = 0; s < 200; s++) begin
         ce_tick();
         st = dut_a.state_q;
         if (st == prev_st) run_len++;
         else begin
            if (prev_st == ST_CLEAR_DLY || prev_st == ST_LINE_DLY || prev_st == ST_REFRESH_DLY) begin
               exp_len = (prev_st == ST_REFRESH_DLY) ? 20 : 4;
               n_runs++;
               checks++;
               if (run_len != exp_len) begin
                  errors++;
                  $display("FAIL dly_len state %0d: got %0d ticks expected %0d", prev_st, run_len, exp_len);
               end
            end
            prev_st = st;
            run_len = 1;
         end
      end
      checks++;
      if (n_runs < 9) begin errors++; $display("FAIL dly_runs: got %0d expected at least 9", n_runs); end
      checks++;
      if (ev_a.size() < 9) begin
         errors++; $display("FAIL cont_events: got %0d expected at least 9", ev_a.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (ev_a[i] != i % 3) begin
               errors++; $display("FAIL cont_order[%0d]: got %0d expected %0d", i, ev_a[i], i % 3);
            end
         end
      end
   endtask

   task automatic test_four_lines();
      logic [3:0] one, exp_line;
      int j;
      one = 4'b0001;
      do_reset(1'b0);
      repeat (250) ce_tick();
      checks++;
      if (ev_b.size() < 10) begin
         errors++; $display("FAIL four_events: got %0d expected at least 10", ev_b.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            j = i % 5;
            checks++;
            if (ev_b[i] != j) begin
               errors++; $display("FAIL four_order[%0d]: got %0d expected %0d", i, ev_b[i], j);
            end
            if (j > 0) begin
               exp_line = one << (j - 1);
               checks++;
               if (evl_b[i] !== exp_line) begin
                  errors++; $display("FAIL four_onehot[%0d]: got %b expected %b", i, evl_b[i], exp_line);
               end
               checks++;
               if (evi_b[i] !== 2'(j - 1)) begin
                  errors++; $display("FAIL four_index[%0d]: got %0d expected %0d", i, evi_b[i], j - 1);
               end
            end
         end
      end
   endtask

   task automatic test_on_demand();
      int bad;
      do_reset(1'b1);
      bad = 0;
      for (int s = 0; s < 1000; s++) begin
         ce_tick();
         if (clr_a !== 1'b0 || line_a !== 2'b00 || idle_a !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ondemand_quiet: got %0d bad ticks expected 0", bad); end
      clear_logs();
      pulse_req_a();
      repeat (300) ce_tick();
      checks++;
      if (count_code(ev_a, 0) != 1) begin
         errors++; $display("FAIL ondemand_one_refresh: got %0d clears expected 1", count_code(ev_a, 0));
      end
      checks++;
      if (count_code(ev_a, 1) + count_code(ev_a, 2) != 2) begin
         errors++; $display("FAIL ondemand_lines: got %0d line writes expected 2",
                            count_code(ev_a, 1) + count_code(ev_a, 2));
      end
      checks++;
      if (idle_a !== 1'b1) begin errors++; $display("FAIL ondemand_idle_after: got %b expected 1", idle_a); end
   endtask

   task automatic test_request_queue();
      clear_logs();
      pulse_req_a();
      wait_state_a(ST_LINE_DLY, "queue_wait_line_dly");
      pulse_req_a();
      repeat (300) ce_tick();
      checks++;
      if (count_code(ev_a, 0) != 2) begin
         errors++; $display("FAIL queue_one_extra: got %0d clears expected 2", count_code(ev_a, 0));
      end
      clear_logs();
      pulse_req_a();
      wait_state_a(ST_CLEAR_DLY, "queue_wait_clear_dly");
      pulse_req_a();
      wait_state_a(ST_LINE_RUN, "queue_wait_line_run");
      pulse_req_a();
      wait_state_a(ST_REFRESH_DLY, "queue_wait_refresh");
      pulse_req_a();
      repeat (300) ce_tick();
      checks++;
      if (count_code(ev_a, 0) != 2) begin
         errors++; $display("FAIL queue_three_pulses: got %0d clears expected 2", count_code(ev_a, 0));
      end
      checks++;
      if (idle_a !== 1'b1) begin errors++; $display("FAIL queue_idle_after: got %b expected 1", idle_a); end
   endtask

   task automatic test_async_reset();
      int n;
      do_reset(1'b0);
      n = 0;
      while (line_a[1] !== 1'b1 && n < 300) begin ce_tick(); n++; end
      checks++;
      if (line_a[1] !== 1'b1) begin errors++; $display("FAIL arst_reach_line1: got %b expected 1", line_a[1]); end
      #7 rst = 1'b1;
      #1;
      checks++; if (line_a !== 2'b00) begin errors++; $display("FAIL arst_lines: got %b expected 00", line_a); end
      checks++; if (idx_a !== 1'b0) begin errors++; $display("FAIL arst_index: got %0d expected 0", idx_a); end
      checks++; if (clr_a !== 1'b0) begin errors++; $display("FAIL arst_clear: got %b expected 0", clr_a); end
      repeat (2) @(negedge clk);
      ready_a = 1'b1; ready_b = 1'b1; ph_a = 0; ph_b = 0;
      prev_clr_a = 1'b0; prev_line_a = '0; prev_clr_b = 1'b0; prev_line_b = '0;
      clear_logs();
      rst = 1'b0;
      #1;
      checks++;
      if (dut_a.state_q != ST_PAUSE) begin
         errors++; $display("FAIL arst_pause: got state %0d expected %0d", dut_a.state_q, ST_PAUSE);
      end
      repeat (20) ce_tick();
      checks++;
      if (ev_a.size() < 2 || ev_a[0] != 0 || ev_a[1] != 1) begin
         errors++; $display("FAIL arst_restart: got %0d events expected clear then line0", ev_a.size());
      end
   endtask

   task automatic test_timeout();
      int bad;
      drv_en_a = 1'b0;
      do_reset(1'b0);
`ifdef LCD_FEED_TIMEOUT_EN
      repeat (50) ce_tick();
      checks++; if (clr_a !== 1'b1) begin errors++; $display("FAIL wd_before_clear: got %b expected 1", clr_a); end
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL wd_before_flag: got %b expected 0", to_a); end
      ce_tick();
      checks++;
      if (dut_a.state_q != ST_PAUSE) begin
         errors++; $display("FAIL wd_pause: got state %0d expected %0d", dut_a.state_q, ST_PAUSE);
      end
      checks++; if (to_a !== 1'b1) begin errors++; $display("FAIL wd_flag: got %b expected 1", to_a); end
      bad = 0;
      for (int s = 0; s < 150; s++) begin ce_tick(); if (to_a !== 1'b1) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL wd_sticky: got %0d ticks cleared expected 0", bad); end
      do_reset(1'b0);
      #1;
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL wd_reset_clear: got %b expected 0", to_a); end
`else
      bad = 0;
      ce_tick();
      for (int s = 0; s < 200; s++) begin
         ce_tick();
         if (clr_a !== 1'b1 || to_a !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nowd_stuck_in_clear: got %0d bad ticks expected 0", bad); end
      checks++;
      if (dut_a.state_q != ST_CLEAR_RUN) begin
         errors++; $display("FAIL nowd_state: got %0d expected %0d", dut_a.state_q, ST_CLEAR_RUN);
      end
`endif
      drv_en_a = 1'b1;
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_four_lines();
      test_on_demand();
      test_request_queue();
      test_async_reset();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
